// File: rtl/rat_io_pkg.sv
// Shared definitions for RAT MCU port-mapped peripherals: the UART TX state
// type, default port IDs and the STATUS byte layout.
package rat_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

  localparam logic [7:0] DEF_DATA_PORT_ID = 8'h40;
  localparam logic [7:0] DEF_STAT_PORT_ID = 8'h41;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  function automatic logic [7:0] pack_status(input logic ovf, input logic busy,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s                 = '0;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// MCU output-bus view seen by port-mapped peripherals: OUT strobe, port ID,
// output data, and the status byte returned toward the IN_PORT mux.
interface uart_tx_port_if;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] STATUS;

  modport master (output IO_STRB, output PORT_ID, output OUT_PORT, input STATUS);
  modport slave  (input IO_STRB, input PORT_ID, input OUT_PORT, output STATUS);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with first-word fall-through read; a push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign drop_o    = push_i && !do_push;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Port-mapped 8N1 UART transmitter: decodes OUT writes into a byte FIFO and
// serialises queued bytes on TX, exposing a pollable status byte.
module uart_tx_port
  import rat_io_pkg::*;
#(
  parameter int         BAUD_DIV     = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] DATA_PORT_ID = DEF_DATA_PORT_ID,
  parameter logic [7:0] STAT_PORT_ID = DEF_STAT_PORT_ID
) (
  input  logic           CLK,
  input  logic           RESET_N,
  uart_tx_port_if.slave  bus,
  output logic           TX
);
  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;

  logic       push_req;
  logic       stat_wr;
  logic       pop;
  logic       baud_done;
  logic [7:0] fifo_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_drop;

  assign push_req = bus.IO_STRB && (bus.PORT_ID == DATA_PORT_ID);
  assign stat_wr  = bus.IO_STRB && (bus.PORT_ID == STAT_PORT_ID);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push_i    (push_req),
    .wr_data_i (bus.OUT_PORT),
    .pop_i     (pop),
    .rd_data_o (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .drop_o    (fifo_drop)
  );

  assign baud_done = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          baud_d  = BAUD_LAST;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d    = BAUD_LAST;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d    = BAUD_LAST;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (baud_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            baud_d  = BAUD_LAST;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX is registered from the next state so the line changes with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (stat_wr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign TX         = tx_q;
  assign bus.STATUS = pack_status(ovf_q, (state_q != ST_IDLE) || !fifo_empty,
                                  fifo_empty, fifo_full);

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomised scoreboard bench for uart_tx_port: a frame-level transmitter
// model predicts STATUS/TX each cycle and queues the bytes a UART receiver must see.
module tb_uart_tx_port;
  localparam int B = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  uart_tx_port_if bus ();

  uart_tx_port #(
    .BAUD_DIV     (B),
    .FIFO_DEPTH   (D),
    .DATA_PORT_ID (8'h40),
    .STAT_PORT_ID (8'h41)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus),
    .TX      (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes, cycles left in the frame on the line,
  // the byte being sent, sticky overflow and frames started.
  logic [7:0] mq[$];
  logic [7:0] expq[$];
  int         rem = 0;
  logic [7:0] cur_byte = 8'h00;
  bit         movf = 1'b0;
  int         frames = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic exp_tx();
    int bitn;
    if (rem == 0) return 1'b1;
    bitn = (10 * B - rem) / B;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    return cur_byte[bitn - 1];
  endfunction

  function automatic logic [7:0] exp_status();
    return {4'b0000, movf, (rem > 0) || (mq.size() > 0), mq.size() == 0, mq.size() == D};
  endfunction

  task automatic model_reset();
    mq.delete();
    expq.delete();
    rem  = 0;
    movf = 1'b0;
  endtask

  // One clock edge of the model, using the inputs presented in that cycle.
  task automatic model_edge(input bit s, input logic [7:0] id, input logic [7:0] d);
    bit push_req, pop_now, acc;
    push_req = s && (id == 8'h40);
    pop_now  = (mq.size() > 0) && (rem <= 1);
    acc      = push_req && ((mq.size() < D) || pop_now);
    if (pop_now) begin
      cur_byte = mq.pop_front();
      expq.push_back(cur_byte);
      rem = 10 * B;
      frames++;
    end else if (rem > 0) begin
      rem--;
    end
    if (acc) mq.push_back(d);
    if (push_req && !acc) movf = 1'b1;
    else if (s && (id == 8'h41)) movf = 1'b0;
  endtask

  task automatic tick(input bit s, input logic [7:0] id, input logic [7:0] d);
    bus.IO_STRB  = s;
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    @(posedge clk);
    model_edge(s, id, d);
    @(negedge clk);
    bus.IO_STRB = 1'b0;
    check8("tx_line", {7'b0, tx}, {7'b0, exp_tx()});
    check8("status", bus.STATUS, exp_status());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((rem > 0) || (mq.size() > 0)) && (n < 2000)) begin
      tick(1'b0, 8'h00, 8'h00);
      n++;
    end
    if (n >= 2000) bound_fail("drain");
    repeat (2) tick(1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_n(input int n, inout bit ok);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) ok = 1'b0;
    end
  endtask

  // Monitor: a UART receiver that pops the scoreboard on each complete frame.
  initial begin : monitor
    bit         ok;
    logic [7:0] b;
    logic [7:0] e;
    logic       start_mid;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (rst_n && (tx == 1'b0)) begin
        ok = 1'b1;
        wait_n(B / 2, ok);
        start_mid = tx;
        for (int k = 0; k < 8; k++) begin
          wait_n(B, ok);
          b[k] = tx;
        end
        wait_n(B, ok);
        stop_bit = tx;
        if (ok) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got byte %02h expected no frame", b);
          end else begin
            e = expq.pop_front();
            check8("frame_start", {7'b0, start_mid}, 8'h00);
            check8("frame_data", b, e);
            check8("frame_stop", {7'b0, stop_bit}, 8'h01);
            $display("frame rx %02h expected %02h at %0t", b, e, $time);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int         n;
    int         f0;
    logic [7:0] id;
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check8("reset_status", bus.STATUS, 8'h02);
    check8("reset_tx", {7'b0, tx}, 8'h01);
    rst_n = 1'b1;

    // Single byte.
    tick(1'b1, 8'h40, 8'hA5);
    repeat (50) tick(1'b0, 8'h00, 8'h00);
    check8("single_idle_status", bus.STATUS, 8'h02);

    // Back-to-back frames.
    tick(1'b1, 8'h40, 8'h01);
    tick(1'b1, 8'h40, 8'h02);
    tick(1'b1, 8'h40, 8'h03);
    repeat (130) tick(1'b0, 8'h00, 8'h00);
    check8("b2b_idle_status", bus.STATUS, 8'h02);

    // Overflow: six bytes in six cycles, then clear via the status port.
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h40, 8'h10 + 8'(i));
    check8("ovf_full_status", bus.STATUS, 8'h0D);
    tick(1'b1, 8'h41, 8'hFF);
    check8("ovf_clear_status", bus.STATUS, 8'h05);
    drain();

    // Full FIFO with a push landing on the stop-end pop.
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h40, 8'h60 + 8'(i));
    n = 0;
    while (!((mq.size() == D) && (rem == 1)) && (n < 200)) begin
      tick(1'b0, 8'h00, 8'h00);
      n++;
    end
    if (n >= 200) bound_fail("full_pop_align");
    tick(1'b1, 8'h40, 8'h6F);
    check8("full_pop_push_status", bus.STATUS, 8'h05);
    drain();

    // Non-matching port IDs.
    for (int i = 0; i < 20; i++) begin
      id = 8'($urandom);
      if ((id == 8'h40) || (id == 8'h41)) id = 8'h42;
      if (i < 5) id = 8'h42;
      tick(1'b1, id, 8'($urandom));
    end
    check8("nomatch_status", bus.STATUS, 8'h02);
    check8("nomatch_tx", {7'b0, tx}, 8'h01);

    // Reset in the middle of the second frame's data bits.
    f0 = frames;
    tick(1'b1, 8'h40, 8'h3C);
    tick(1'b1, 8'h40, 8'hC3);
    n = 0;
    while (!((frames == f0 + 2) && (rem <= 9 * B) && (rem > B)) && (n < 200)) begin
      tick(1'b0, 8'h00, 8'h00);
      n++;
    end
    if (n >= 200) bound_fail("midframe_align");
    #1 rst_n = 1'b0;
    #1;
    check8("midreset_tx", {7'b0, tx}, 8'h01);
    check8("midreset_status", bus.STATUS, 8'h02);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) tick(1'b0, 8'h00, 8'h00);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4: id = 8'h40;
        5:             id = 8'h41;
        6:             id = 8'h42;
        default:       id = 8'($urandom);
      endcase
      tick(($urandom_range(0, 2) == 0), id, 8'($urandom));
    end
    drain();
    repeat (B) tick(1'b0, 8'h00, 8'h00);
    check8("scoreboard_empty", 8'(expq.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
